// File: rtl/snitch_pkg.sv
// Shared Snitch types used by the LSU reorder buffer: memory request/response
// structs and the meta-id that tags each in-flight transaction.
package snitch_pkg;

  localparam int unsigned NumIntOutstandingLoads = 8;
  localparam int unsigned MetaIdWidth = 3;

  typedef logic [MetaIdWidth-1:0] meta_id_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  amo;
    logic [31:0] data;
    logic [3:0]  strb;
    meta_id_t    id;
  } dreq_t;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
    meta_id_t    id;
  } dresp_t;

endpackage

// File: rtl/snitch_lsu_rob.sv
// Reorder buffer between the Snitch LSU and the data port: tags requests with
// a slot id, absorbs out-of-order responses and retires them in issue order.
module snitch_lsu_rob
  import snitch_pkg::*;
#(
  parameter int unsigned NumOutstanding = NumIntOutstandingLoads,
  parameter int unsigned TagWidth       = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                core_qvalid_i,
  output logic                core_qready_o,
  input  logic [31:0]         core_qaddr_i,
  input  logic                core_qwrite_i,
  input  logic [3:0]          core_qamo_i,
  input  logic [31:0]         core_qdata_i,
  input  logic [3:0]          core_qstrb_i,
  input  logic [TagWidth-1:0] core_qtag_i,
  output logic                core_pvalid_o,
  input  logic                core_pready_i,
  output logic [31:0]         core_pdata_o,
  output logic                core_perror_o,
  output logic [TagWidth-1:0] core_ptag_o,
  output logic                data_qvalid_o,
  input  logic                data_qready_i,
  output dreq_t               data_q_o,
  input  logic                data_pvalid_i,
  output logic                data_pready_o,
  input  dresp_t              data_p_i
);

  localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);

  typedef struct packed {
    logic                write;
    logic                error;
    logic [TagWidth-1:0] tag;
    logic [31:0]         data;
  } rob_slot_t;

  logic [NumOutstanding-1:0]     busy_q, busy_d, done_q, done_d;
  rob_slot_t [NumOutstanding-1:0] slot_q, slot_d;
  meta_id_t                      head_q, head_d, tail_q, tail_d;
  logic [CntWidth-1:0]           count_q, count_d;
  logic                          full, alloc, head_ready, retire;
  rob_slot_t                     head_slot;

  assign full          = (count_q == CntWidth'(NumOutstanding));
  assign data_qvalid_o = core_qvalid_i & ~full;
  assign core_qready_o = data_qready_i & ~full;
  assign alloc         = core_qvalid_i & data_qready_i & ~full;
  assign data_pready_o = 1'b1;

  always_comb begin
    data_q_o       = '0;
    data_q_o.addr  = core_qaddr_i;
    data_q_o.write = core_qwrite_i;
    data_q_o.amo   = core_qamo_i;
    data_q_o.data  = core_qdata_i;
    data_q_o.strb  = core_qstrb_i;
    data_q_o.id    = tail_q;
  end

  // Stores retire without a core response; loads/AMOs wait for core_pready_i.
  assign head_slot     = slot_q[head_q];
  assign head_ready    = busy_q[head_q] & done_q[head_q];
  assign core_pvalid_o = head_ready & ~head_slot.write;
  assign retire        = head_ready & (head_slot.write | core_pready_i);
  assign core_pdata_o  = core_pvalid_o ? head_slot.data : '0;
  assign core_perror_o = core_pvalid_o & head_slot.error;
  assign core_ptag_o   = core_pvalid_o ? head_slot.tag : '0;

  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    slot_d  = slot_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CntWidth'(alloc) - CntWidth'(retire);
    if (retire) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d = (head_q == meta_id_t'(NumOutstanding - 1)) ? '0 : head_q + meta_id_t'(1);
    end
    if (alloc) begin
      busy_d[tail_q]       = 1'b1;
      done_d[tail_q]       = 1'b0;
      slot_d[tail_q].write = core_qwrite_i;
      slot_d[tail_q].tag   = core_qtag_i;
      tail_d = (tail_q == meta_id_t'(NumOutstanding - 1)) ? '0 : tail_q + meta_id_t'(1);
    end
    if (data_pvalid_i) begin
      slot_d[data_p_i.id].data  = data_p_i.data;
      slot_d[data_p_i.id].error = data_p_i.error;
      done_d[data_p_i.id]       = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= '0;
      done_q  <= '0;
      slot_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      slot_q  <= slot_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Responses must target an allocated slot that has not yet been answered;
  // this also catches stale ids from before a reset.
  a_resp_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_pvalid_i |-> (32'(data_p_i.id) < NumOutstanding) &&
                      busy_q[data_p_i.id] && !done_q[data_p_i.id]);

endmodule

// File: tb/tb_snitch_lsu_rob.sv
// Directed bench for the LSU reorder buffer: ordering, full, stores,
// back-pressure, simultaneous alloc/retire, wrap and async reset.
module tb_snitch_lsu_rob;
  import snitch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        core_qvalid_i = 1'b0;
  logic        core_qready_o;
  logic [31:0] core_qaddr_i = '0;
  logic        core_qwrite_i = 1'b0;
  logic [3:0]  core_qamo_i = '0;
  logic [31:0] core_qdata_i = '0;
  logic [3:0]  core_qstrb_i = '0;
  logic [4:0]  core_qtag_i = '0;
  logic        core_pvalid_o;
  logic        core_pready_i = 1'b1;
  logic [31:0] core_pdata_o;
  logic        core_perror_o;
  logic [4:0]  core_ptag_o;
  logic        data_qvalid_o;
  logic        data_qready_i = 1'b1;
  dreq_t       data_q_o;
  logic        data_pvalid_i = 1'b0;
  logic        data_pready_o;
  dresp_t      data_p_i = '0;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  snitch_lsu_rob #(.NumOutstanding(8), .TagWidth(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_qvalid_i(core_qvalid_i), .core_qready_o(core_qready_o),
    .core_qaddr_i(core_qaddr_i), .core_qwrite_i(core_qwrite_i),
    .core_qamo_i(core_qamo_i), .core_qdata_i(core_qdata_i),
    .core_qstrb_i(core_qstrb_i), .core_qtag_i(core_qtag_i),
    .core_pvalid_o(core_pvalid_o), .core_pready_i(core_pready_i),
    .core_pdata_o(core_pdata_o), .core_perror_o(core_perror_o),
    .core_ptag_o(core_ptag_o),
    .data_qvalid_o(data_qvalid_o), .data_qready_i(data_qready_i),
    .data_q_o(data_q_o),
    .data_pvalid_i(data_pvalid_i), .data_pready_o(data_pready_o),
    .data_p_i(data_p_i)
  );

  task automatic do_reset();
    core_qvalid_i = 1'b0;
    data_pvalid_i = 1'b0;
    core_pready_i = 1'b1;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic issue(input logic wr, input logic [4:0] tag, input logic [31:0] addr,
                       output meta_id_t id);
    int n = 0;
    core_qvalid_i = 1'b1;
    core_qwrite_i = wr;
    core_qtag_i   = tag;
    core_qaddr_i  = addr;
    core_qdata_i  = addr ^ 32'h5A5A_0000;
    core_qstrb_i  = 4'hF;
    #1;
    while (!core_qready_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    total++;
    if (!core_qready_o) begin
      $display("FAIL issue_wait: ready=%0b after %0d cycles, required 1", core_qready_o, n);
      bad++;
    end
    id = data_q_o.id;
    @(posedge clk_i); #1;
    core_qvalid_i = 1'b0;
  endtask

  task automatic respond(input meta_id_t id, input logic [31:0] d, input logic err);
    data_pvalid_i  = 1'b1;
    data_p_i.id    = id;
    data_p_i.data  = d;
    data_p_i.error = err;
    @(posedge clk_i); #1;
    data_pvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (core_pvalid_o !== 1'b0) begin $display("FAIL rst_pvalid: got %0b want 0", core_pvalid_o); bad++; end
    total++; if (core_pdata_o !== 32'h0) begin $display("FAIL rst_pdata: got %h want 0", core_pdata_o); bad++; end
    total++; if (core_perror_o !== 1'b0) begin $display("FAIL rst_perror: got %0b want 0", core_perror_o); bad++; end
    total++; if (core_ptag_o !== 5'd0) begin $display("FAIL rst_ptag: got %0d want 0", core_ptag_o); bad++; end
    total++; if (data_qvalid_o !== 1'b0) begin $display("FAIL rst_qvalid: got %0b want 0", data_qvalid_o); bad++; end
    total++; if (core_qready_o !== 1'b1) begin $display("FAIL rst_qready: got %0b want 1", core_qready_o); bad++; end
    total++; if (data_pready_o !== 1'b1) begin $display("FAIL rst_pready: got %0b want 1", data_pready_o); bad++; end
    // Request path is combinational; drop valid again before the next edge.
    core_qvalid_i = 1'b1; core_qaddr_i = 32'h0000_1234; core_qwrite_i = 1'b1;
    core_qamo_i = 4'h3; core_qdata_i = 32'hCAFE_F00D; core_qstrb_i = 4'h6;
    #1;
    total++; if (data_qvalid_o !== 1'b1) begin $display("FAIL req_qvalid: got %0b want 1", data_qvalid_o); bad++; end
    total++;
    if (data_q_o.addr !== 32'h1234 || data_q_o.write !== 1'b1 || data_q_o.amo !== 4'h3 ||
        data_q_o.data !== 32'hCAFE_F00D || data_q_o.strb !== 4'h6 || data_q_o.id !== 3'd0) begin
      $display("FAIL req_fields: got addr=%h w=%0b amo=%h data=%h strb=%h id=%0d want 1234/1/3/cafef00d/6/0",
               data_q_o.addr, data_q_o.write, data_q_o.amo, data_q_o.data, data_q_o.strb, data_q_o.id);
      bad++;
    end
    core_qvalid_i = 1'b0; core_qwrite_i = 1'b0; core_qamo_i = 4'h0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_ordering();
    meta_id_t id0, id1, id2;
    do_reset();
    issue(1'b0, 5'd1, 32'h100, id0);
    issue(1'b0, 5'd2, 32'h104, id1);
    issue(1'b0, 5'd3, 32'h108, id2);
    total++;
    if (id0 !== 3'd0 || id1 !== 3'd1 || id2 !== 3'd2) begin
      $display("FAIL ord_ids: got %0d,%0d,%0d want 0,1,2", id0, id1, id2); bad++;
    end
    respond(3'd2, 32'hC, 1'b0);
    total++; if (core_pvalid_o !== 1'b0) begin $display("FAIL ord_nohead: pvalid=%0b want 0", core_pvalid_o); bad++; end
    data_pvalid_i = 1'b1; data_p_i.id = 3'd0; data_p_i.data = 32'hA; data_p_i.error = 1'b0;
    #1;
    total++; if (core_pvalid_o !== 1'b0) begin $display("FAIL ord_latency: pvalid=%0b want 0", core_pvalid_o); bad++; end
    @(posedge clk_i); #1;
    data_p_i.id = 3'd1; data_p_i.data = 32'hB;
    total++;
    if (core_pvalid_o !== 1'b1 || core_pdata_o !== 32'hA || core_ptag_o !== 5'd1) begin
      $display("FAIL ord_first: got v=%0b d=%h t=%0d want 1/a/1", core_pvalid_o, core_pdata_o, core_ptag_o); bad++;
    end
    @(posedge clk_i); #1;
    data_pvalid_i = 1'b0;
    total++;
    if (core_pvalid_o !== 1'b1 || core_pdata_o !== 32'hB || core_ptag_o !== 5'd2) begin
      $display("FAIL ord_second: got v=%0b d=%h t=%0d want 1/b/2", core_pvalid_o, core_pdata_o, core_ptag_o); bad++;
    end
    @(posedge clk_i); #1;
    total++;
    if (core_pvalid_o !== 1'b1 || core_pdata_o !== 32'hC || core_ptag_o !== 5'd3) begin
      $display("FAIL ord_third: got v=%0b d=%h t=%0d want 1/c/3", core_pvalid_o, core_pdata_o, core_ptag_o); bad++;
    end
    @(posedge clk_i); #1;
    total++; if (core_pvalid_o !== 1'b0) begin $display("FAIL ord_empty: pvalid=%0b want 0", core_pvalid_o); bad++; end
  endtask

  task automatic test_full();
    meta_id_t id;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 5'(i), 32'h200 + 32'(i), id);
      total++;
      if (id !== 3'(i)) begin $display("FAIL full_id%0d: got %0d want %0d", i, id, i); bad++; end
    end
    core_qvalid_i = 1'b1; core_qtag_i = 5'd20;
    #1;
    total++;
    if (core_qready_o !== 1'b0 || data_qvalid_o !== 1'b0) begin
      $display("FAIL full_block: got ready=%0b qvalid=%0b want 0/0", core_qready_o, data_qvalid_o); bad++;
    end
    respond(3'd0, 32'h55, 1'b0);
    total++;
    if (core_pvalid_o !== 1'b1 || core_qready_o !== 1'b0 || data_qvalid_o !== 1'b0) begin
      $display("FAIL full_nobypass: got pvalid=%0b ready=%0b qvalid=%0b want 1/0/0",
               core_pvalid_o, core_qready_o, data_qvalid_o); bad++;
    end
    @(posedge clk_i); #1;
    total++;
    if (core_qready_o !== 1'b1 || data_qvalid_o !== 1'b1 || data_q_o.id !== 3'd0) begin
      $display("FAIL full_reopen: got ready=%0b qvalid=%0b id=%0d want 1/1/0",
               core_qready_o, data_qvalid_o, data_q_o.id); bad++;
    end
    @(posedge clk_i); #1;
    core_qvalid_i = 1'b0;
  endtask

  task automatic test_stores();
    meta_id_t ids, idl;
    int pulses = 0;
    logic [31:0] seen_d = '0;
    logic [4:0] seen_t = '0;
    do_reset();
    issue(1'b1, 5'd0, 32'h300, ids);
    issue(1'b0, 5'd9, 32'h304, idl);
    total++;
    if (ids !== 3'd0 || idl !== 3'd1) begin $display("FAIL st_ids: got %0d,%0d want 0,1", ids, idl); bad++; end
    respond(3'd1, 32'h11, 1'b0);
    respond(3'd0, 32'h0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (core_pvalid_o === 1'b1) begin
        pulses++; seen_d = core_pdata_o; seen_t = core_ptag_o;
      end
      @(posedge clk_i); #1;
    end
    total++; if (pulses != 1) begin $display("FAIL st_pulses: got %0d want 1", pulses); bad++; end
    total++;
    if (seen_d !== 32'h11 || seen_t !== 5'd9) begin
      $display("FAIL st_load: got d=%h t=%0d want 11/9", seen_d, seen_t); bad++;
    end
  endtask

  task automatic test_backpressure();
    meta_id_t id;
    do_reset();
    issue(1'b0, 5'd7, 32'h400, id);
    core_pready_i = 1'b0;
    respond(id, 32'hDEAD, 1'b1);
    for (int c = 0; c < 5; c++) begin
      total++;
      if (core_pvalid_o !== 1'b1 || core_pdata_o !== 32'hDEAD || core_perror_o !== 1'b1 || core_ptag_o !== 5'd7) begin
        $display("FAIL bp_stall%0d: got v=%0b d=%h e=%0b t=%0d want 1/dead/1/7",
                 c, core_pvalid_o, core_pdata_o, core_perror_o, core_ptag_o); bad++;
      end
      @(posedge clk_i); #1;
    end
    core_pready_i = 1'b1;
    @(posedge clk_i); #1;
    total++; if (core_pvalid_o !== 1'b0) begin $display("FAIL bp_pop: pvalid=%0b want 0", core_pvalid_o); bad++; end
  endtask

  task automatic test_simultaneous();
    meta_id_t id;
    do_reset();
    for (int i = 0; i < 3; i++) issue(1'b0, 5'(i + 1), 32'h500, id);
    respond(3'd0, 32'h77, 1'b0);
    core_qvalid_i = 1'b1; core_qtag_i = 5'd4;
    #1;
    total++;
    if (core_pvalid_o !== 1'b1 || core_qready_o !== 1'b1 || data_q_o.id !== 3'd3) begin
      $display("FAIL sim_both: got pvalid=%0b ready=%0b id=%0d want 1/1/3", core_pvalid_o, core_qready_o, data_q_o.id); bad++;
    end
    @(posedge clk_i); #1;
    core_qvalid_i = 1'b0;
    // Three remain in flight, so exactly five more fit before full.
    for (int i = 0; i < 5; i++) issue(1'b0, 5'd10, 32'h504, id);
    total++; if (id !== 3'd0) begin $display("FAIL sim_wrapid: got %0d want 0", id); bad++; end
    core_qvalid_i = 1'b1;
    #1;
    total++; if (core_qready_o !== 1'b0) begin $display("FAIL sim_full: ready=%0b want 0", core_qready_o); bad++; end
    core_qvalid_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_wrap();
    meta_id_t id;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      issue(1'b0, 5'(i), 32'h600 + 32'(i), id);
      total++;
      if (id !== 3'(i % 8)) begin $display("FAIL wrap_id%0d: got %0d want %0d", i, id, i % 8); bad++; end
      respond(id, 32'h1000 + 32'(i), 1'b0);
      total++;
      if (core_pvalid_o !== 1'b1 || core_pdata_o !== 32'h1000 + 32'(i) || core_ptag_o !== 5'(i)) begin
        $display("FAIL wrap_resp%0d: got v=%0b d=%h t=%0d want 1/%h/%0d",
                 i, core_pvalid_o, core_pdata_o, core_ptag_o, 32'h1000 + 32'(i), i); bad++;
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_mid_reset();
    meta_id_t id;
    do_reset();
    core_pready_i = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, 5'(i + 5), 32'h700, id);
    respond(3'd0, 32'hAB, 1'b1);
    total++; if (core_pvalid_o !== 1'b1) begin $display("FAIL mr_pre: pvalid=%0b want 1", core_pvalid_o); bad++; end
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if (core_pvalid_o !== 1'b0 || core_pdata_o !== 32'h0 || core_perror_o !== 1'b0 ||
        core_ptag_o !== 5'd0 || core_qready_o !== 1'b1 || data_qvalid_o !== 1'b0) begin
      $display("FAIL mr_async: got v=%0b d=%h e=%0b t=%0d rdy=%0b qv=%0b want 0/0/0/0/1/0",
               core_pvalid_o, core_pdata_o, core_perror_o, core_ptag_o, core_qready_o, data_qvalid_o); bad++;
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    core_pready_i = 1'b1;
    @(posedge clk_i); #1;
    issue(1'b0, 5'd1, 32'h800, id);
    total++; if (id !== 3'd0) begin $display("FAIL mr_firstid: got %0d want 0", id); bad++; end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_full();
    test_stores();
    test_backpressure();
    test_simultaneous();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
